hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_scoreboard.sv | 48 ++++
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared register-file geometry and control FSM encoding for the hazard controller.
package hazard_pkg;
    localparam int REG_AW = 5;
    localparam int REG_N = 32;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/branch/write-back inputs and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if;
    import hazard_pkg::*;
    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs_addr;
    logic [REG_AW-1:0] dec_rt_addr;
    logic              dec_uses_rs;
    logic              dec_uses_rt;
    logic [REG_AW-1:0] dec_dst_addr;
    logic              dec_reg_write;
    logic              dec_branch;
    logic              dec_jump;
    logic              br_resolved;
    logic              br_taken;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_addr;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              redirect;
    ctrl_state_t       ctrl_state;
    logic [REG_N-1:0]  pending_mask;
    logic              timeout_err;
    modport master (
        output dec_valid, dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt, dec_dst_addr,
        output dec_reg_write, dec_branch, dec_jump, br_resolved, br_taken, wb_reg_write, wb_addr,
        input  stall_if, stall_id, bubble_ex, redirect, ctrl_state, pending_mask, timeout_err
    );
    modport slave (
        input  dec_valid, dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt, dec_dst_addr,
        input  dec_reg_write, dec_branch, dec_jump, br_resolved, br_taken, wb_reg_write, wb_addr,
        output stall_if, stall_id, bubble_ex, redirect, ctrl_state, pending_mask, timeout_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters with issue/write-back update.
// HAZARD_WB_BYPASS_EN: report registers whose single pending write retires this cycle as released.
module hazard_scoreboard import hazard_pkg::*; #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic [REG_AW-1:0] i_inc_addr,
    input  logic              i_dec,
    input  logic [REG_AW-1:0] i_dec_addr,
    output logic [REG_N-1:0]  o_pending,
    output logic [REG_N-1:0]  o_full,
    output logic [REG_N-1:0]  o_release
);
    logic [PEND_W-1:0] r_cnt [REG_N];
    logic [REG_N-1:0]  w_inc;
    logic [REG_N-1:0]  w_dec;
    // Register 0 is left out of every mask so it never pends or hazards.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        o_pending = '0;
        o_full = '0;
        o_release = '0;
        for (int k = 1; k < REG_N; k++) begin
            w_inc[k] = i_inc && i_inc_addr == REG_AW'(k);
            w_dec[k] = i_dec && i_dec_addr == REG_AW'(k);
            o_pending[k] = r_cnt[k] != '0;
            o_full[k] = r_cnt[k] == '1;
`ifdef HAZARD_WB_BYPASS_EN
            o_release[k] = w_dec[k] && r_cnt[k] == PEND_W'(1);
`else
            o_release[k] = 1'b0;
`endif
        end
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < REG_N; k++) begin
            if (rst)
                r_cnt[k] <= '0;
            else if (w_inc[k] && !w_dec[k] && r_cnt[k] != '1)
                r_cnt[k] <= r_cnt[k] + 1'b1;
            else if (w_dec[k] && !w_inc[k] && r_cnt[k] != '0)
                r_cnt[k] <= r_cnt[k] - 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: data-hazard stall generation and branch/jump resolution FSM with timeout.
// HAZARD_WB_BYPASS_EN (in hazard_scoreboard) lets a source retiring its last write this cycle proceed.
module hazard_ctrl import hazard_pkg::*; #(
    parameter int RESOLVE_TIMEOUT = 4,
    parameter int PEND_W = 2
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(RESOLVE_TIMEOUT + 1);
    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic [REG_N-1:0]  w_pend;
    logic [REG_N-1:0]  w_full;
    logic [REG_N-1:0]  w_release;
    logic [REG_N-1:0]  w_busy;
    logic              w_haz;
    logic              w_issue;

    hazard_scoreboard #(.PEND_W(PEND_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_issue && bus.dec_reg_write),
        .i_inc_addr (bus.dec_dst_addr),
        .i_dec      (bus.wb_reg_write),
        .i_dec_addr (bus.wb_addr),
        .o_pending  (w_pend),
        .o_full     (w_full),
        .o_release  (w_release)
    );

    assign w_busy = w_pend & ~w_release;
    // A saturated destination counter is handled exactly like a source hazard.
    assign w_haz = bus.dec_valid && ((bus.dec_uses_rs && w_busy[bus.dec_rs_addr]) ||
                   (bus.dec_uses_rt && w_busy[bus.dec_rt_addr]) ||
                   (bus.dec_reg_write && w_full[bus.dec_dst_addr]));
    assign w_issue = bus.dec_valid && !w_haz;

    always_comb begin
        w_next = r_state;
        w_wait_next = '0;
        w_timeout_next = r_timeout;
        case (r_state)
            RUN: w_next = (w_issue && (bus.dec_branch || bus.dec_jump)) ? CTRL_WAIT : RUN;
            CTRL_WAIT: begin
                w_wait_next = r_wait + 1'b1;
                if (bus.br_resolved) begin
                    w_next = bus.br_taken ? REDIRECT : RUN;
                    w_wait_next = '0;
                end else if (w_wait_next == WAIT_W'(RESOLVE_TIMEOUT)) begin
                    w_next = RUN;
                    w_wait_next = '0;
                    w_timeout_next = 1'b1;
                end
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_wait <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait <= w_wait_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Outputs are forced quiet while reset is asserted, regardless of decode inputs.
    assign bus.stall_id = !rst && w_haz;
    assign bus.stall_if = !rst && ((r_state == RUN && w_haz) || r_state == CTRL_WAIT);
    assign bus.bubble_ex = !rst && (w_haz || r_state != RUN);
    assign bus.redirect = !rst && r_state == REDIRECT;
    assign bus.ctrl_state = rst ? RUN : r_state;
    assign bus.pending_mask = rst ? '0 : w_pend;
    assign bus.timeout_err = !rst && r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of scoreboard stalls, branch FSM, timeout and reset behaviour.
module tb_hazard_ctrl;
`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int n_tests = 0;
    int n_fail = 0;

    hazard_ctrl_if bus ();
    hazard_ctrl #(.RESOLVE_TIMEOUT(4), .PEND_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.dec_valid = 0; bus.dec_rs_addr = 0; bus.dec_rt_addr = 0;
        bus.dec_uses_rs = 0; bus.dec_uses_rt = 0; bus.dec_dst_addr = 0;
        bus.dec_reg_write = 0; bus.dec_branch = 0; bus.dec_jump = 0;
        bus.br_resolved = 0; bus.br_taken = 0; bus.wb_reg_write = 0; bus.wb_addr = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        cyc(); bus.dec_valid = 1; bus.dec_branch = 1; #1;
        chk("rst_stall_if", bus.stall_if, 0);
        chk("rst_bubble", bus.bubble_ex, 0);
        chk("rst_state", bus.ctrl_state, 0);
        cyc(); #1;
        chk("rst_state_hold", bus.ctrl_state, 0);
        clr(); rst = 0; #1;
        chk("post_rst_mask", bus.pending_mask, 0);
        chk("post_rst_timeout", bus.timeout_err, 0);
        chk("post_rst_redirect", bus.redirect, 0);
        chk("post_rst_stall_id", bus.stall_id, 0);
        // RAW dependency on r5
        cyc(); bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_dst_addr = 5; #1;
        chk("a_issue", bus.stall_id, 0);
        cyc(); bus.dec_uses_rs = 1; bus.dec_rs_addr = 5; bus.dec_dst_addr = 6; #1;
        chk("a_mask5", bus.pending_mask, 32'h20);
        chk("a_stall_id", bus.stall_id, 1);
        chk("a_bubble", bus.bubble_ex, 1);
        chk("a_stall_if", bus.stall_if, 1);
        cyc(); #1;
        chk("a_stall_hold", bus.stall_id, 1);
        bus.wb_reg_write = 1; bus.wb_addr = 5; #1;
        chk("a_wb_cycle", bus.stall_id, BYP ? 0 : 1);
        cyc(); bus.dec_valid = 0; bus.wb_reg_write = 0; #1;
        chk("a_mask_after_wb", bus.pending_mask, BYP ? 32'h40 : 32'h0);
        chk("a_no_stall", bus.stall_id, 0);
        bus.wb_reg_write = 1; bus.wb_addr = 6;
        cyc(); clr(); #1;
        chk("a_mask_clean", bus.pending_mask, 0);
        // taken branch
        cyc(); bus.dec_valid = 1; bus.dec_branch = 1; #1;
        chk("b_issue", bus.stall_id, 0);
        chk("b_state_run", bus.ctrl_state, 0);
        cyc(); clr(); #1;
        chk("b_wait_state", bus.ctrl_state, 1);
        chk("b_wait_stall_if", bus.stall_if, 1);
        chk("b_wait_bubble", bus.bubble_ex, 1);
        chk("b_wait_stall_id", bus.stall_id, 0);
        chk("b_wait_redirect", bus.redirect, 0);
        cyc(); bus.br_resolved = 1; bus.br_taken = 1; #1;
        chk("b_wait2_state", bus.ctrl_state, 1);
        chk("b_wait2_stall_if", bus.stall_if, 1);
        cyc(); clr(); #1;
        chk("b_redir_state", bus.ctrl_state, 2);
        chk("b_redirect", bus.redirect, 1);
        chk("b_redir_bubble", bus.bubble_ex, 1);
        chk("b_redir_stall_if", bus.stall_if, 0);
        cyc(); #1;
        chk("b_run_state", bus.ctrl_state, 0);
        chk("b_redirect_once", bus.redirect, 0);
        chk("b_run_bubble", bus.bubble_ex, 0);
        // not-taken branch
        cyc(); bus.dec_valid = 1; bus.dec_branch = 1;
        cyc(); clr(); bus.br_resolved = 1; #1;
        chk("nt_wait_state", bus.ctrl_state, 1);
        cyc(); clr(); #1;
        chk("nt_state", bus.ctrl_state, 0);
        chk("nt_redirect", bus.redirect, 0);
        // resolution timeout
        cyc(); bus.dec_valid = 1; bus.dec_jump = 1;
        cyc(); clr(); #1;
        chk("c_w0_state", bus.ctrl_state, 1);
        cyc(); cyc(); cyc(); #1;
        chk("c_w3_state", bus.ctrl_state, 1);
        chk("c_w3_timeout", bus.timeout_err, 0);
        cyc(); #1;
        chk("c_timeout", bus.timeout_err, 1);
        chk("c_state_run", bus.ctrl_state, 0);
        bus.br_resolved = 1; bus.br_taken = 1;
        cyc(); clr(); #1;
        chk("c_stray_state", bus.ctrl_state, 0);
        chk("c_stray_redirect", bus.redirect, 0);
        cyc(); #1;
        chk("c_sticky", bus.timeout_err, 1);
        // saturation on r7
        cyc(); bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_dst_addr = 7; #1;
        chk("d_w1", bus.stall_id, 0);
        cyc(); #1;
        chk("d_w2", bus.stall_id, 0);
        cyc(); #1;
        chk("d_w3", bus.stall_id, 0);
        cyc(); #1;
        chk("d_sat_stall", bus.stall_id, 1);
        chk("d_mask7", bus.pending_mask, 32'h80);
        bus.wb_reg_write = 1; bus.wb_addr = 7; #1;
        chk("d_sat_wb_cycle", bus.stall_id, 1);
        cyc(); bus.wb_reg_write = 0; #1;
        chk("d_released", bus.stall_id, 0);
        cyc(); bus.dec_valid = 0; bus.dec_reg_write = 0; bus.wb_reg_write = 1; bus.wb_addr = 7;
        cyc(); cyc(); cyc(); clr(); #1;
        chk("d_mask_clean", bus.pending_mask, 0);
        // same-cycle issue/wb on r9 and bypass behaviour
        cyc(); bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_dst_addr = 9;
        cyc(); bus.wb_reg_write = 1; bus.wb_addr = 9; #1;
        chk("e_issue_wb", bus.stall_id, 0);
        chk("e_mask9", bus.pending_mask, 32'h200);
        cyc(); bus.dec_reg_write = 0; bus.dec_dst_addr = 0; bus.dec_uses_rt = 1; bus.dec_rt_addr = 9; #1;
        chk("e_mask_stay", bus.pending_mask, 32'h200);
        chk("e_cnt1_wb_stall", bus.stall_id, BYP ? 0 : 1);
        cyc(); clr(); #1;
        chk("e_mask_clean", bus.pending_mask, 0);
        bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_dst_addr = 9;
        cyc(); cyc(); bus.dec_reg_write = 0; bus.dec_dst_addr = 0; bus.dec_uses_rs = 1; bus.dec_rs_addr = 9;
        bus.wb_reg_write = 1; bus.wb_addr = 9; #1;
        chk("e_cnt2_stall", bus.stall_id, 1);
        cyc(); #1;
        chk("e_cnt1_stall", bus.stall_id, BYP ? 0 : 1);
        cyc(); bus.wb_reg_write = 0; #1;
        chk("e_cnt0_go", bus.stall_id, 0);
        bus.dec_rs_addr = 0; #1;
        chk("e_r0_src", bus.stall_id, 0);
        // reset during CTRL_WAIT with r3 pending
        cyc(); clr(); bus.dec_valid = 1; bus.dec_reg_write = 1; bus.dec_dst_addr = 3;
        cyc(); bus.dec_reg_write = 0; bus.dec_dst_addr = 0; bus.dec_branch = 1;
        cyc(); clr(); #1;
        chk("f_wait_state", bus.ctrl_state, 1);
        chk("f_mask3", bus.pending_mask, 32'h8);
        rst = 1; #1;
        chk("f_rst_stall_if", bus.stall_if, 0);
        chk("f_rst_mask", bus.pending_mask, 0);
        cyc(); rst = 0; #1;
        chk("f_post_mask", bus.pending_mask, 0);
        chk("f_post_state", bus.ctrl_state, 0);
        chk("f_post_stall_if", bus.stall_if, 0);
        chk("f_post_bubble", bus.bubble_ex, 0);
        chk("f_post_timeout", bus.timeout_err, 0);
        bus.br_resolved = 1; bus.br_taken = 1;
        cyc(); clr(); #1;
        chk("f_no_redirect", bus.redirect, 0);
        chk("f_state_run", bus.ctrl_state, 0);
        cyc(); #1;
        chk("f_no_redirect2", bus.redirect, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
